// File: rtl/dvi_timing_sequencer_if.sv
// -----------------------------------------------------------------------------
// dvi_timing_sequencer_if
// Groups the pixel-source handshake and the video output bus of the DVI timing
// sequencer.
//
// Signals:
//   px_req  - pixel request to the source (sequencer -> source)
//   px_x    - requested column, 0 when px_req=0
//   px_y    - requested row, 0 when px_req=0
//   px_rgb  - source pixel, valid exactly one cycle after px_req (source -> sequencer)
//   de      - data enable to the TMDS encoders
//   hsync   - horizontal sync
//   vsync   - vertical sync
//   rgb     - pixel data to the encoders, 0 whenever de=0
//
// Modports:
//   master - the sequencer: drives requests and video, reads px_rgb
//   slave  - source/sink side: reads requests and video, drives px_rgb
// -----------------------------------------------------------------------------
interface dvi_timing_sequencer_if;
  logic        px_req;
  logic [9:0]  px_x;
  logic [9:0]  px_y;
  logic [23:0] px_rgb;
  logic        de;
  logic        hsync;
  logic        vsync;
  logic [23:0] rgb;

  modport master (
    output px_req, px_x, px_y, de, hsync, vsync, rgb,
    input  px_rgb
  );

  modport slave (
    input  px_req, px_x, px_y, de, hsync, vsync, rgb,
    output px_rgb
  );
endinterface

// File: rtl/dvi_timing_sequencer.sv
// -----------------------------------------------------------------------------
// dvi_timing_sequencer
// Generates DVI raster timing from a single pixel clock. A small FSM
// (IDLE/RUN/STOP) gates a horizontal/vertical position counter. The counter
// state requests pixels from a source and is decoded into de/hsync/vsync,
// which pass through a two-stage register pipeline so that video leaves the
// block two cycles after the counter state that produced it. The source's
// one-cycle-latency pixel is captured into the second stage.
//
// Ports:
//   clk         - pixel clock; the only clock
//   rst_n       - asynchronous active-low reset
//   enable      - request that video runs; dropping it finishes the frame
//   busy        - FSM not idle, or pipeline still holds de or an active sync
//   frame_start - one-cycle pulse while pixel (0,0) is being requested
//   frame_cnt   - number of completed frames (wraps at 16 bits)
//   vid         - pixel request / video output bus (master side)
// -----------------------------------------------------------------------------
module dvi_timing_sequencer #(
  parameter int H_ACTIVE = 640,
  parameter int H_FP     = 16,
  parameter int H_SYNC   = 96,
  parameter int H_BP     = 48,
  parameter int V_ACTIVE = 480,
  parameter int V_FP     = 10,
  parameter int V_SYNC   = 2,
  parameter int V_BP     = 33,
  parameter bit SYNC_POL = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     enable,
  output logic                     busy,
  output logic                     frame_start,
  output logic [15:0]              frame_cnt,
  dvi_timing_sequencer_if.master   vid
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS_END  = 10'(H_ACTIVE);
  localparam logic [9:0] V_VIS_END  = 10'(V_ACTIVE);
  localparam logic [9:0] H_SYNC_BEG = 10'(H_ACTIVE + H_FP);
  localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_BEG = 10'(V_ACTIVE + V_FP);
  localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    STOP = 2'd2
  } state_e;

  state_e      state_q, state_d;
  logic [9:0]  h_q, h_d;
  logic [9:0]  v_q, v_d;
  logic [15:0] frame_cnt_q, frame_cnt_d;

  // Stage 1: decoded from the counter state of the previous cycle.
  logic        de1_q, de1_d;
  logic        hs1_q, hs1_d;
  logic        vs1_q, vs1_d;
  // Stage 2: drives the outputs; rgb joins here because px_rgb arrives
  // one cycle after the request, i.e. alongside stage 1.
  logic        de2_q;
  logic        hs2_q;
  logic        vs2_q;
  logic [23:0] rgb_q, rgb_d;

  logic running;
  logic h_last;
  logic v_last;
  logic eof;
  logic visible;
  logic hs_win;
  logic vs_win;

  assign running = (state_q != IDLE);
  assign h_last  = (h_q == H_LAST);
  assign v_last  = (v_q == V_LAST);
  assign eof     = h_last && v_last;

  // All decodes are qualified by running: in IDLE the counter sits at (0,0),
  // which would otherwise look like a visible pixel.
  assign visible = running && (h_q < H_VIS_END) && (v_q < V_VIS_END);
  assign hs_win  = running && (h_q >= H_SYNC_BEG) && (h_q < H_SYNC_END);
  assign vs_win  = running && (v_q >= V_SYNC_BEG) && (v_q < V_SYNC_END);

  // Next state, position counter and frame counter.
  always_comb begin
    state_d     = state_q;
    h_d         = h_q;
    v_d         = v_q;
    frame_cnt_d = frame_cnt_q;

    case (state_q)
      IDLE: begin
        if (enable) state_d = RUN;
      end
      RUN: begin
        if (!enable) state_d = STOP;
      end
      STOP: begin
        // enable wins over the end-of-frame drop to IDLE.
        if (enable)   state_d = RUN;
        else if (eof) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (running) begin
      if (h_last) begin
        h_d = '0;
        v_d = v_last ? '0 : v_q + 10'd1;
      end else begin
        h_d = h_q + 10'd1;
      end
      if (eof) frame_cnt_d = frame_cnt_q + 16'd1;
    end else begin
      h_d = '0;
      v_d = '0;
    end
  end

  // Pipeline stage inputs.
  always_comb begin
    de1_d = visible;
    hs1_d = hs_win ? SYNC_POL : ~SYNC_POL;
    vs1_d = vs_win ? SYNC_POL : ~SYNC_POL;
    rgb_d = de1_q ? vid.px_rgb : 24'd0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      h_q         <= '0;
      v_q         <= '0;
      frame_cnt_q <= '0;
      de1_q       <= 1'b0;
      hs1_q       <= ~SYNC_POL;
      vs1_q       <= ~SYNC_POL;
      de2_q       <= 1'b0;
      hs2_q       <= ~SYNC_POL;
      vs2_q       <= ~SYNC_POL;
      rgb_q       <= '0;
    end else begin
      state_q     <= state_d;
      h_q         <= h_d;
      v_q         <= v_d;
      frame_cnt_q <= frame_cnt_d;
      de1_q       <= de1_d;
      hs1_q       <= hs1_d;
      vs1_q       <= vs1_d;
      de2_q       <= de1_q;
      hs2_q       <= hs1_q;
      vs2_q       <= vs1_q;
      rgb_q       <= rgb_d;
    end
  end

  assign vid.px_req = visible;
  assign vid.px_x   = visible ? h_q : 10'd0;
  assign vid.px_y   = visible ? v_q : 10'd0;
  assign vid.de     = de2_q;
  assign vid.hsync  = hs2_q;
  assign vid.vsync  = vs2_q;
  assign vid.rgb    = rgb_q;

  assign frame_start = running && (h_q == 10'd0) && (v_q == 10'd0);
  assign frame_cnt   = frame_cnt_q;

  // Busy stays up until nothing meaningful is left in flight.
  assign busy = running
              | de1_q | (hs1_q == SYNC_POL) | (vs1_q == SYNC_POL)
              | de2_q | (hs2_q == SYNC_POL) | (vs2_q == SYNC_POL);

endmodule

// File: tb/tb_dvi_timing_sequencer.sv
// -----------------------------------------------------------------------------
// tb_dvi_timing_sequencer
// Directed scenarios on a tiny raster (8 x 6) with a frame-level model that
// tracks the position as a single pixel index and delays decoded video by two
// cycles through a queue-like pair of snapshots. Every falling edge compares all
// outputs with the model; per-scenario recordings are then checked against
// hand-computed cycle numbers.
// -----------------------------------------------------------------------------
module tb_dvi_timing_sequencer;

  localparam int HA = 4, HF = 1, HS = 2, HB = 1;
  localparam int VA = 3, VF = 1, VS = 1, VB = 1;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam int FT = HT * VT;
  localparam int NREC = 200;

  logic        clk    = 1'b0;
  logic        rst_n  = 1'b1;
  logic        enable = 1'b0;
  logic        busy;
  logic        frame_start;
  logic [15:0] frame_cnt;

  dvi_timing_sequencer_if vif();

  dvi_timing_sequencer #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
    .SYNC_POL(1'b0)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .busy       (busy),
    .frame_start(frame_start),
    .frame_cnt  (frame_cnt),
    .vid        (vif)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  // ---------------- frame-level model ----------------
  typedef enum int {M_IDLE, M_RUN, M_STOP} mmode_e;
  typedef struct packed {
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] pix;
  } stage_t;

  mmode_e mmode = M_IDLE;
  int     mpos  = 0;     // pixel index within the frame, h = mpos % HT, v = mpos / HT
  int     mfcnt = 0;
  stage_t st1, st2;      // st2 is what appears on the outputs

  function automatic stage_t look(input bit act, input int p);
    stage_t s;
    int h, v;
    h = p % HT;
    v = p / HT;
    s.de  = act && (h < HA) && (v < VA);
    s.hs  = act && (h >= HA + HF) && (h < HA + HF + HS);
    s.vs  = act && (v >= VA + VF) && (v < VA + VF + VS);
    s.pix = 24'((v << 10) | h);
    return s;
  endfunction

  task automatic model_reset();
    mmode = M_IDLE;
    mpos  = 0;
    mfcnt = 0;
    st1   = look(1'b0, 0);
    st2   = st1;
  endtask

  task automatic model_step(input bit en);
    bit eof;
    st2 = st1;
    st1 = look(mmode != M_IDLE, mpos);
    eof = (mpos == FT - 1);
    case (mmode)
      M_IDLE: if (en) begin mmode = M_RUN; mpos = 0; end
      M_RUN: begin
        if (eof) mfcnt = (mfcnt + 1) & 16'hFFFF;
        mpos = (mpos + 1) % FT;
        if (!en) mmode = M_STOP;
      end
      default: begin
        if (eof) mfcnt = (mfcnt + 1) & 16'hFFFF;
        mpos = (mpos + 1) % FT;
        if (en) mmode = M_RUN;
        else if (eof) begin mmode = M_IDLE; mpos = 0; end
      end
    endcase
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else        model_step(enable);
    end
  end

  // ---------------- cycle-by-cycle compare ----------------
  bit chk_on = 1'b0;

  initial forever begin
    @(negedge clk);
    if (chk_on) begin
      bit act, vis, bz;
      int h, v;
      act = (mmode != M_IDLE);
      h   = act ? mpos % HT : 0;
      v   = act ? mpos / HT : 0;
      vis = act && (h < HA) && (v < VA);
      bz  = act || st1.de || st1.hs || st1.vs || st2.de || st2.hs || st2.vs;
      chk("px_req", vif.px_req, vis);
      chk("px_x", vif.px_x, vis ? h : 0);
      chk("px_y", vif.px_y, vis ? v : 0);
      chk("frame_start", frame_start, act && (mpos == 0));
      chk("frame_cnt", frame_cnt, mfcnt);
      chk("de", vif.de, st2.de);
      chk("hsync", vif.hsync, !st2.hs);
      chk("vsync", vif.vsync, !st2.vs);
      chk("rgb", vif.rgb, st2.de ? st2.pix : 24'd0);
      chk("busy", busy, bz);
    end
  end

  // ---------------- pixel source: {px_y, px_x}, 1-cycle latency ----------------
  initial begin
    logic [23:0] pend;
    vif.px_rgb = 24'hFFFFFF;
    forever begin
      @(negedge clk);
      pend = vif.px_req ? {4'h0, vif.px_y, vif.px_x} : 24'hFFFFFF;
      @(posedge clk);
      #1;
      vif.px_rgb = pend;
    end
  end

  // ---------------- per-scenario recorder ----------------
  logic        rec_fs  [NREC];
  logic        rec_req [NREC];
  logic        rec_de  [NREC];
  logic        rec_hs  [NREC];
  logic        rec_vs  [NREC];
  logic        rec_busy[NREC];
  logic [9:0]  rec_x   [NREC];
  logic [23:0] rec_rgb [NREC];
  logic [15:0] rec_fc  [NREC];
  int rec_idx = 0;
  bit rec_on  = 1'b0;

  initial forever begin
    @(negedge clk);
    if (rec_on && rec_idx < NREC) begin
      rec_fs[rec_idx]   = frame_start;
      rec_req[rec_idx]  = vif.px_req;
      rec_de[rec_idx]   = vif.de;
      rec_hs[rec_idx]   = vif.hsync;
      rec_vs[rec_idx]   = vif.vsync;
      rec_busy[rec_idx] = busy;
      rec_x[rec_idx]    = vif.px_x;
      rec_rgb[rec_idx]  = vif.rgb;
      rec_fc[rec_idx]   = frame_cnt;
      rec_idx++;
    end
  end

  // ---------------- stimulus ----------------
  int cur = 0;

  task automatic adv_to(input int k);
    while (cur < k) begin
      @(posedge clk);
      #1;
      cur++;
    end
  endtask

  // Reset, then raise enable: the cycle in which enable first reads 1 is cycle 0.
  task automatic restart();
    enable = 1'b0;
    rec_on = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(posedge clk); #1;
    enable  = 1'b1;
    rec_idx = 0;
    rec_on  = 1'b1;
    cur     = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    #2;
    rst_n  = 1'b0;
    chk_on = 1'b1;
    @(posedge clk); #1;
    $display("reset: checking idle output values");
    chk("rst_busy", busy, 1'b0);
    chk("rst_fs", frame_start, 1'b0);
    chk("rst_req", vif.px_req, 1'b0);
    chk("rst_de", vif.de, 1'b0);
    chk("rst_hsync", vif.hsync, 1'b1);
    chk("rst_vsync", vif.vsync, 1'b1);
    chk("rst_rgb", vif.rgb, 24'd0);
    chk("rst_fc", frame_cnt, 16'd0);

    // Free run for three frames.
    restart();
    adv_to(150);
    $display("scenario free_run: 150 cycles, frame_cnt=%0d", frame_cnt);
    chk("A_fs0", rec_fs[0], 1'b0);
    chk("A_fs1", rec_fs[1], 1'b1);
    for (int c = 0; c <= 6; c++) chk("A_req", rec_req[c], (c >= 1 && c <= 4));
    for (int c = 1; c <= 4; c++) chk("A_px_x", rec_x[c], c - 1);
    for (int c = 2; c <= 7; c++) chk("A_de", rec_de[c], (c >= 3 && c <= 6));
    for (int c = 7; c <= 10; c++) chk("A_hsync", rec_hs[c], !(c == 8 || c == 9));
    chk("A_rgb4", rec_rgb[4], 24'h000001);
    chk("A_rgb7", rec_rgb[7], 24'h000000);
    chk("A_rgb12", rec_rgb[12], 24'h000401);
    n = 0;
    for (int c = 0; c < 150; c++) if (rec_vs[c] == 1'b0) n++;
    chk("A_vsync_low_count", n, 24);
    chk("A_vs34", rec_vs[34], 1'b1);
    chk("A_vs35", rec_vs[35], 1'b0);
    chk("A_vs42", rec_vs[42], 1'b0);
    chk("A_vs43", rec_vs[43], 1'b1);
    chk("A_fc144", rec_fc[144], 16'd2);
    chk("A_fc145", rec_fc[145], 16'd3);

    // Enable dropped at h=2, v=1 (cycle 11): frame completes, then idle.
    restart();
    adv_to(11);
    enable = 1'b0;
    adv_to(55);
    $display("scenario stop_mid_frame: frame_cnt=%0d busy=%0b", frame_cnt, busy);
    chk("B_busy48", rec_busy[48], 1'b1);
    chk("B_busy49", rec_busy[49], 1'b1);
    chk("B_busy50", rec_busy[50], 1'b0);
    chk("B_hs49", rec_hs[49], 1'b0);
    chk("B_fs49", rec_fs[49], 1'b0);
    chk("B_fc50", rec_fc[50], 16'd1);

    // Enable dropped and reasserted in the same frame: no gap.
    restart();
    adv_to(11);
    enable = 1'b0;
    adv_to(20);
    enable = 1'b1;
    adv_to(60);
    $display("scenario stop_resume: frame_cnt=%0d", frame_cnt);
    n = 0;
    for (int c = 2; c <= 48; c++) if (rec_fs[c]) n++;
    chk("C_no_early_fs", n, 0);
    chk("C_fs49", rec_fs[49], 1'b1);
    n = 0;
    for (int c = 1; c <= 55; c++) if (!rec_busy[c]) n++;
    chk("C_busy_gaps", n, 0);

    // Enable dropped exactly in the end-of-frame cycle while running.
    restart();
    adv_to(48);
    enable = 1'b0;
    adv_to(100);
    $display("scenario stop_at_eof: frame_cnt=%0d", frame_cnt);
    chk("E_fs49", rec_fs[49], 1'b1);
    chk("E_busy97", rec_busy[97], 1'b1);
    chk("E_busy98", rec_busy[98], 1'b0);
    chk("E_fc98", rec_fc[98], 16'd2);

    // Reset pulse at v=2 with enable held high.
    restart();
    adv_to(20);
    chk("D_de_before", vif.de, 1'b1);
    rst_n = 1'b0;
    #1;
    $display("scenario reset_mid_frame: reset asserted at cycle 20");
    chk("D_busy", busy, 1'b0);
    chk("D_de", vif.de, 1'b0);
    chk("D_rgb", vif.rgb, 24'd0);
    chk("D_req", vif.px_req, 1'b0);
    chk("D_hsync", vif.hsync, 1'b1);
    chk("D_vsync", vif.vsync, 1'b1);
    chk("D_fs", frame_start, 1'b0);
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    @(negedge clk);
    chk("D_fs_release", frame_start, 1'b0);
    @(negedge clk);
    chk("D_fs_after", frame_start, 1'b1);
    chk("D_fc_after", frame_cnt, 16'd0);
    chk("D_req_after", vif.px_req, 1'b1);
    @(posedge clk); #1;

    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dvi_timing_sequencer.md
DVI_TIMING_SEQUENCER -- requirements
Module: dvi_timing_sequencer

Interface
REQ-001 SHALL have these parameters (name, default, meaning):
- H_ACTIVE, 640, visible pixels per line
- H_FP, 16, horizontal front porch in pixels
- H_SYNC, 96, hsync width in pixels
- H_BP, 48, horizontal back porch in pixels
- V_ACTIVE, 480, visible lines
- V_FP, 10, vertical front porch in lines
- V_SYNC, 2, vsync width in lines
- V_BP, 33, vertical back porch in lines
- SYNC_POL, 0, active level of hsync and vsync
REQ-002 SHALL have these ports (name, direction, width, meaning):
- clk, in, 1, pixel clock; the only clock
- rst_n, in, 1, asynchronous active-low reset
- enable, in, 1, request that video runs
- busy, out, 1, sequencer or pipeline not idle
- frame_start, out, 1, one-cycle pulse when pixel (0,0) is requested
- px_req, out, 1, pixel request to the source
- px_x, out, 10, requested column
- px_y, out, 10, requested row
- px_rgb, in, 24, source pixel; valid exactly 1 cycle after px_req
- de, out, 1, data enable to the TMDS encoders
- hsync, out, 1, horizontal sync
- vsync, out, 1, vertical sync
- rgb, out, 24, pixel data to the encoders
- frame_cnt, out, 16, number of completed frames

Function
REQ-003 SHALL define H_TOTAL as the sum of the four H parameters and V_TOTAL as the sum of the four V parameters; counters h in 0..H_TOTAL-1 and v in 0..V_TOTAL-1.
REQ-004 SHALL implement FSM states IDLE, RUN and STOP.
REQ-005 In IDLE, h and v SHALL be held at 0 and no px_req SHALL be issued.
REQ-006 Transition IDLE->RUN SHALL occur on the first clk edge with enable=1; in the following cycle h=0, v=0 and frame_start=1.
REQ-007 In RUN and STOP, h SHALL increment every cycle; at h=H_TOTAL-1, h SHALL wrap to 0 and v SHALL increment; at v=V_TOTAL-1 together with h=H_TOTAL-1, v SHALL wrap to 0.
REQ-008 In RUN, enable=0 SHALL cause RUN->STOP; the frame continues unchanged.
REQ-009 In STOP, enable=1 SHALL cause STOP->RUN with no counter disturbance.
REQ-010 At the end of frame (h=H_TOTAL-1, v=V_TOTAL-1) in STOP, the FSM SHALL go to IDLE; if enable=1 in that same cycle, RUN takes priority.
REQ-011 frame_cnt SHALL increment by 1 at every end of frame in RUN or STOP, and SHALL wrap from 0xFFFF to 0.
REQ-012 px_req SHALL be 1 iff the state is not IDLE, h<H_ACTIVE and v<V_ACTIVE; px_x=h and px_y=v when px_req=1, otherwise 0.
REQ-013 frame_start SHALL be 1 iff the state is not IDLE, h=0 and v=0.
REQ-014 hsync SHALL equal SYNC_POL while H_ACTIVE+H_FP <= h < H_ACTIVE+H_FP+H_SYNC, and !SYNC_POL otherwise.
REQ-015 vsync SHALL equal SYNC_POL while V_ACTIVE+V_FP <= v < V_ACTIVE+V_FP+V_SYNC, and !SYNC_POL otherwise.
REQ-016 de, hsync, vsync and rgb SHALL be registered 2 cycles after the counter state that produced them; rgb SHALL be px_rgb when the delayed de=1, otherwise 0.
REQ-017 While the FSM is IDLE, the delayed sync stage SHALL be fed the inactive level (!SYNC_POL) and de=0.
REQ-018 busy SHALL be 1 when the state is not IDLE or either pipeline stage holds de=1 or an active sync.

Reset
REQ-019 When rst_n=0, all of the following SHALL apply asynchronously: FSM=IDLE, h=v=0, frame_cnt=0, px_req=0, frame_start=0, de=0, rgb=0, hsync=vsync=!SYNC_POL, busy=0, pipeline cleared.
REQ-020 Reset asserted mid-frame SHALL abort the frame immediately; after release the block waits in IDLE for enable.

Verification
Bench parameters: H 4/1/2/1 (H_TOTAL=8), V 3/1/1/1 (V_TOTAL=6), SYNC_POL=0.
REQ-021 Scenario: enable=1 at cycle 0 -> frame_start=1 at cycle 1; px_req cycles 1-4 with px_x 0..3; de=1 cycles 3-6; hsync=0 for the two cycles starting at cycle 8.
REQ-022 Scenario: source returns px_rgb = {px_y, px_x} with 1-cycle latency -> rgb matches at every de=1; rgb=0 whenever de=0.
REQ-023 Scenario: run 3 full frames (144 cycles) -> frame_cnt=3; vsync=0 exactly for rows v=4 in each frame (8 cycles each).
REQ-024 Scenario: enable dropped at h=2, v=1 -> frame completes; FSM IDLE after cycle 48; busy falls 2 cycles later; frame_cnt=1.
REQ-025 Scenario: enable dropped then reasserted within the same frame -> no gap; the next frame_start occurs exactly 48 cycles after the previous one.
REQ-026 Scenario: rst_n pulsed low at v=2 -> all outputs at reset values immediately; with enable=1 held, frame_start occurs 1 cycle after rst_n release; frame_cnt=0.
